sd_cmd_phy: RTL and testbench
=============================

Name: sd_cmd_phy

Overview:
- Command-line physical stage for the SD host; sits directly upstream of the bidirectional CMD pad cell.
- Serializes a 48-bit command MSB-first into the pad, then turns the line around.
- Hunts for the card's response start bit under a timeout, deserializes the response, and hands it to the command controller over a valid/ack handshake.

Parameters:
- CMD_BITS, 48, command frame length in bits.
- RESP_BITS, 48, response frame length in bits, start bit included.
- TIMEOUT, 64, maximum clocks to wait for the response start bit after turnaround.

Ports:
- clock  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- strobe_in  in  1  start request; sampled only in IDLE.
- cmd_in  in  CMD_BITS  command frame; latched on an accepted strobe.
- has_response  in  1  1 = expect a response; latched with cmd_in.
- ack_in  in  1  controller acknowledge of done_out.
- pad_data_in  out  1  serial bit to the pad (pad's data_in).
- pad_output_input  out  1  pad direction: 1 = drive card, 0 = receive.
- pad_enable  out  1  pad enable.
- pad_data_out  in  1  serial bit from the pad; registered one clock inside the pad.
- resp_out  out  RESP_BITS  received response, first bit received in the MSB.
- done_out  out  1  transaction complete; held until ack_in.
- timeout_err  out  1  no start bit within TIMEOUT; valid while done_out=1.
- busy_out  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, all outputs 0, resp_out=0, shift register and counters cleared. Reset mid-transaction aborts immediately; pad_enable drops in the same instant.
- States and actions:
  - IDLE: on strobe_in=1, latch cmd_in and has_response, go to PRIME. Otherwise stay.
  - PRIME (1 clk): pad_enable=1, pad_output_input=1, pad_data_in=1. The pad ignores data_in on its first enabled cycle, so this cycle exists only to arm it.
  - SEND (CMD_BITS clks): pad_data_in = bit CMD_BITS-1 down to bit 0, one bit per clock. Bit counter runs 0..CMD_BITS-1. After the last bit: go to TURN if has_response=1, else go to DONE.
  - TURN: pad_output_input=0, pad_enable stays 1, wait counter starts at 0.
    - pad_data_out === 1'b0 (a definite 0 only; 1/z/x do not count): capture that bit as resp bit RESP_BITS-1, go to RECV.
    - Wait counter reaches TIMEOUT-1 with no start bit: set timeout_err=1, go to DONE.
  - RECV (RESP_BITS-1 clks): shift pad_data_out into resp_out MSB-first. After the final bit go to DONE.
  - DONE: pad_enable=0, pad_output_input=0, done_out=1, resp_out stable. On ack_in=1: clear done_out and timeout_err, go to IDLE. busy_out drops on the same edge.
- Latency with no response: strobe sampled at edge E. PRIME occupies E+1. Command bits occupy E+2..E+CMD_BITS+1. done_out is high from E+CMD_BITS+2 (E+50 at default).
- strobe_in while busy_out=1: ignored, not queued.
- ack_in outside DONE: ignored.
- ack_in already high on entry to DONE: done_out is visible for one cycle, then IDLE.
- A start bit on the first TURN cycle is accepted (wait count 0).
- Counter widths: ceiling log2 of max(CMD_BITS, RESP_BITS, TIMEOUT). No wrap is permitted in any state.
- resp_out is not cleared at a new strobe. It updates only during RECV, so a timed-out transaction leaves the previous value intact.

Test Plan:
- Reset, then strobe with cmd_in=48'h40_0000_0000_95, has_response=0 -> one PRIME cycle; pad_data_in sequence 0,1,0...,1,0,0,1,0,1,0,1 over 48 clocks; done_out high at E+50; timeout_err=0; pad_enable=0 in DONE.
- cmd_in=48'h48_0000_01AA_87, has_response=1; model card drives 1 for 5 clks after turnaround, then frame 48'h08_0000_01AA_13 MSB-first -> resp_out=48'h08_0000_01AA_13, done_out=1, timeout_err=0.
- has_response=1, card holds 1 (and separately z) -> after exactly 64 TURN clocks: done_out=1, timeout_err=1, resp_out unchanged from the prior test.
- Strobe pulsed again on bit 10 of SEND -> ignored; serialized frame unchanged; exactly one done_out.
- reset=0 asserted mid-SEND (bit 20) and mid-RECV -> all outputs 0 immediately, without waiting for a clock edge; next strobe after release runs a clean full transaction.
- ack_in held low 10 clks in DONE -> done_out and resp_out stable throughout; ack_in=1 -> IDLE next edge, busy_out=0.

Source files
------------

// File: rtl/sd_cmd_phy.sv
// sd_cmd_phy -- command-line physical stage for the SD host.
//
// Sits directly upstream of the bidirectional CMD pad cell. It serializes a
// command frame MSB-first into the pad and then turns the line around. After
// that it hunts for the card's response start bit within a bounded wait,
// deserializes the response, and hands the result to the command controller
// over a done/ack handshake.
//
// Ports
//   clock            system clock, all logic on the rising edge
//   reset            asynchronous, active-low reset
//   strobe_in        start request, sampled only while idle
//   cmd_in           command frame, latched on an accepted strobe
//   has_response     1 = expect a response, latched with cmd_in
//   ack_in           controller acknowledge of done_out
//   pad_data_in      serial bit towards the pad
//   pad_output_input pad direction: 1 = drive card, 0 = receive
//   pad_enable       pad enable
//   pad_data_out     serial bit from the pad (already registered in the pad)
//   resp_out         received response, first received bit in the MSB
//   done_out         transaction complete, held until ack_in
//   timeout_err      no start bit within TIMEOUT clocks, valid with done_out
//   busy_out         high in every state except IDLE
//
// Every output is a flop. Each output flop is loaded from the value that
// belongs to the next state, so the outputs line up with the state register.
module sd_cmd_phy #(
  parameter int CMD_BITS  = 48,
  parameter int RESP_BITS = 48,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 strobe_in,
  input  logic [CMD_BITS-1:0]  cmd_in,
  input  logic                 has_response,
  input  logic                 ack_in,
  output logic                 pad_data_in,
  output logic                 pad_output_input,
  output logic                 pad_enable,
  input  logic                 pad_data_out,
  output logic [RESP_BITS-1:0] resp_out,
  output logic                 done_out,
  output logic                 timeout_err,
  output logic                 busy_out
);

  // One counter is shared by SEND, TURN and RECV. It is sized for the longest
  // of the three phases so that it never wraps.
  localparam int MAX_CNT = (CMD_BITS > RESP_BITS) ?
                           ((CMD_BITS > TIMEOUT) ? CMD_BITS : TIMEOUT) :
                           ((RESP_BITS > TIMEOUT) ? RESP_BITS : TIMEOUT);
  localparam int CNT_W = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RECV_LAST = CNT_W'(RESP_BITS - 2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_SEND  = 3'd2,
    ST_TURN  = 3'd3,
    ST_RECV  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t                state_r, state_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic [CMD_BITS-1:0]   cmd_sh_r, cmd_sh_s;
  logic                  has_resp_r, has_resp_s;
  logic [RESP_BITS-1:0]  resp_r, resp_s;
  logic                  pad_data_r, pad_data_s;
  logic                  pad_dir_r, pad_dir_s;
  logic                  pad_en_r, pad_en_s;
  logic                  done_r, done_s;
  logic                  tmo_r, tmo_s;
  logic                  busy_r, busy_s;

  // State register, shared counter, shift registers and output flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      cmd_sh_r   <= '0;
      has_resp_r <= 1'b0;
      resp_r     <= '0;
      pad_data_r <= 1'b0;
      pad_dir_r  <= 1'b0;
      pad_en_r   <= 1'b0;
      done_r     <= 1'b0;
      tmo_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      cmd_sh_r   <= cmd_sh_s;
      has_resp_r <= has_resp_s;
      resp_r     <= resp_s;
      pad_data_r <= pad_data_s;
      pad_dir_r  <= pad_dir_s;
      pad_en_r   <= pad_en_s;
      done_r     <= done_s;
      tmo_r      <= tmo_s;
      busy_r     <= busy_s;
    end
  end

  // Next-state, counter, shift and next-output logic.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    cmd_sh_s   = cmd_sh_r;
    has_resp_s = has_resp_r;
    resp_s     = resp_r;
    tmo_s      = tmo_r;
    pad_data_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (strobe_in) begin
          cmd_sh_s   = cmd_in;
          has_resp_s = has_response;
          tmo_s      = 1'b0;
          state_s    = ST_PRIME;
          // The pad ignores data on its first enabled cycle; drive idle-high.
          pad_data_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRIME: begin
        state_s    = ST_SEND;
        cnt_s      = CNT_ZERO;
        pad_data_s = cmd_sh_r[CMD_BITS-1];
        cmd_sh_s   = {cmd_sh_r[CMD_BITS-2:0], 1'b0};
      end
      ST_SEND: begin
        if (cnt_r == SEND_LAST) begin
          cnt_s = CNT_ZERO;
          if (has_resp_r) begin
            state_s = ST_TURN;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          cnt_s      = cnt_r + CNT_ONE;
          pad_data_s = cmd_sh_r[CMD_BITS-1];
          cmd_sh_s   = {cmd_sh_r[CMD_BITS-2:0], 1'b0};
        end
      end
      ST_TURN: begin
        // Only a definite 0 is a start bit; a floating or unknown line is not.
        if (pad_data_out === 1'b0) begin
          resp_s  = {resp_r[RESP_BITS-2:0], 1'b0};
          cnt_s   = CNT_ZERO;
          state_s = ST_RECV;
        end else if (cnt_r == WAIT_LAST) begin
          tmo_s   = 1'b1;
          cnt_s   = CNT_ZERO;
          state_s = ST_DONE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_RECV: begin
        resp_s = {resp_r[RESP_BITS-2:0], pad_data_out};
        if (cnt_r == RECV_LAST) begin
          cnt_s   = CNT_ZERO;
          state_s = ST_DONE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DONE: begin
        if (ack_in) begin
          tmo_s   = 1'b0;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
        tmo_s   = 1'b0;
      end
    endcase
  end

  // Pad control and status outputs that belong to the next state.
  always_comb begin
    pad_en_s  = 1'b0;
    pad_dir_s = 1'b0;
    done_s    = 1'b0;
    busy_s    = 1'b1;
    case (state_s)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_PRIME, ST_SEND: begin
        pad_en_s  = 1'b1;
        pad_dir_s = 1'b1;
      end
      ST_TURN, ST_RECV: begin
        pad_en_s = 1'b1;
      end
      ST_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  assign pad_data_in      = pad_data_r;
  assign pad_output_input = pad_dir_r;
  assign pad_enable       = pad_en_r;
  assign resp_out         = resp_r;
  assign done_out         = done_r;
  assign timeout_err      = tmo_r;
  assign busy_out         = busy_r;

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Directed bench for sd_cmd_phy with hand-computed expected frames.
module tb_sd_cmd_phy;

  logic        clock;
  logic        reset;
  logic        strobe_in;
  logic [47:0] cmd_in;
  logic        has_response;
  logic        ack_in;
  logic        pad_data_in;
  logic        pad_output_input;
  logic        pad_enable;
  logic        pad_data_out;
  logic [47:0] resp_out;
  logic        done_out;
  logic        timeout_err;
  logic        busy_out;

  int n_cmp = 0;
  int n_bad = 0;

  sd_cmd_phy #(.CMD_BITS(48), .RESP_BITS(48), .TIMEOUT(64)) dut (
    .clock            (clock),
    .reset            (reset),
    .strobe_in        (strobe_in),
    .cmd_in           (cmd_in),
    .has_response     (has_response),
    .ack_in           (ack_in),
    .pad_data_in      (pad_data_in),
    .pad_output_input (pad_output_input),
    .pad_enable       (pad_enable),
    .pad_data_out     (pad_data_out),
    .resp_out         (resp_out),
    .done_out         (done_out),
    .timeout_err      (timeout_err),
    .busy_out         (busy_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise strobe for one edge, then check the PRIME cycle.
  task automatic go(input logic [47:0] cmd, input logic hr);
    @(negedge clock);
    cmd_in       = cmd;
    has_response = hr;
    strobe_in    = 1'b1;
    @(posedge clock); #1;
    strobe_in = 1'b0;
    cmd_in    = ~cmd;
    chk("prime_en",   pad_enable, 1);
    chk("prime_dir",  pad_output_input, 1);
    chk("prime_data", pad_data_in, 1);
    chk("prime_busy", busy_out, 1);
  endtask

  // Collect the 48 serialized bits; optionally pulse strobe after bit pulse_at.
  task automatic send_frame(input logic [47:0] cmd, input int pulse_at);
    logic [47:0] got;
    logic        drive_ok;
    got      = '0;
    drive_ok = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(posedge clock); #1;
      got[47-i] = pad_data_in;
      if (!(pad_enable && pad_output_input)) drive_ok = 1'b0;
      strobe_in = (i == pulse_at);
    end
    strobe_in = 1'b0;
    chk("send_frame", got, cmd);
    chk("send_drive", drive_ok, 1);
    chk("send_done_low", done_out, 0);
  endtask

  // Card answers with frame after 'delay' clocks of idle-high line.
  task automatic card_reply(input logic [47:0] frame, input int delay);
    pad_data_out = 1'b1;
    for (int i = 0; i < delay; i++) begin
      @(posedge clock); #1;
    end
    chk("turn_en",  pad_enable, 1);
    chk("turn_dir", pad_output_input, 0);
    for (int i = 0; i < 48; i++) begin
      pad_data_out = frame[47-i];
      @(posedge clock); #1;
    end
    pad_data_out = 1'b1;
  endtask

  task automatic ack_and_idle();
    ack_in = 1'b1;
    @(posedge clock); #1;
    ack_in = 1'b0;
    chk("ack_done", done_out, 0);
    chk("ack_busy", busy_out, 0);
    chk("ack_tmo",  timeout_err, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {busy_out, done_out, timeout_err, pad_enable, pad_output_input, pad_data_in}, 6'b0);
    chk({tag, "_resp"}, resp_out, 48'h0);
  endtask

  initial begin
    logic [47:0] c1, c2, c3, r2, r3;
    logic        stable;
    c1 = 48'h40_0000_0000_95;
    c2 = 48'h48_0000_01AA_87;
    c3 = 48'h4A_1234_5678_C3;
    r2 = 48'h08_0000_01AA_13;
    r3 = 48'h3F_0000_0900_FF;

    reset        = 1'b0;
    strobe_in    = 1'b0;
    cmd_in       = '0;
    has_response = 1'b0;
    ack_in       = 1'b0;
    pad_data_out = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;

    // No-response command: done appears on the edge after the last bit.
    go(c1, 1'b0);
    send_frame(c1, -1);
    @(posedge clock); #1;
    chk("t1_done", done_out, 1);
    chk("t1_tmo",  timeout_err, 0);
    chk("t1_pad",  {pad_enable, pad_output_input}, 2'b00);
    chk("t1_busy", busy_out, 1);
    ack_and_idle();

    // Response after 5 idle-high clocks; then hold ack low 10 clocks.
    go(c2, 1'b1);
    send_frame(c2, -1);
    @(posedge clock); #1;
    card_reply(r2, 5);
    chk("t2_done", done_out, 1);
    chk("t2_resp", resp_out, r2);
    chk("t2_tmo",  timeout_err, 0);
    chk("t2_pad",  pad_enable, 0);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (done_out !== 1'b1 || resp_out !== r2) stable = 1'b0;
    end
    chk("t2_hold", stable, 1);
    ack_and_idle();

    // Card never answers: exactly 64 TURN clocks then timeout.
    go(c2, 1'b1);
    send_frame(c2, -1);
    @(posedge clock); #1;
    repeat (63) @(posedge clock);
    #1;
    chk("t3_early", done_out, 0);
    @(posedge clock); #1;
    chk("t3_done", done_out, 1);
    chk("t3_tmo",  timeout_err, 1);
    chk("t3_resp", resp_out, r2);
    ack_and_idle();

    // Strobe pulsed mid-SEND is ignored; one done only.
    go(c1, 1'b0);
    send_frame(c1, 10);
    @(posedge clock); #1;
    chk("t4_done", done_out, 1);
    ack_and_idle();
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (busy_out !== 1'b0 || done_out !== 1'b0) stable = 1'b0;
    end
    chk("t4_noqueue", stable, 1);

    // ack already high on DONE entry: done visible one cycle only.
    go(c3, 1'b0);
    ack_in = 1'b1;
    send_frame(c3, -1);
    @(posedge clock); #1;
    chk("t5_done", done_out, 1);
    @(posedge clock); #1;
    chk("t5_gone", done_out, 0);
    chk("t5_busy", busy_out, 0);
    ack_in = 1'b0;

    // Reset mid-SEND aborts without a clock edge, then a clean run.
    go(c2, 1'b0);
    repeat (21) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_all_zero("t6_abort");
    @(negedge clock);
    reset = 1'b1;
    go(c1, 1'b0);
    send_frame(c1, -1);
    @(posedge clock); #1;
    chk("t6_done", done_out, 1);
    ack_and_idle();

    // Reset mid-RECV, then a response whose start bit arrives at wait count 0.
    go(c2, 1'b1);
    send_frame(c2, -1);
    @(posedge clock); #1;
    for (int i = 0; i < 12; i++) begin
      pad_data_out = r2[47-i];
      @(posedge clock); #1;
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_all_zero("t7_abort");
    pad_data_out = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    go(c3, 1'b1);
    send_frame(c3, -1);
    @(posedge clock); #1;
    card_reply(r3, 0);
    chk("t7_done", done_out, 1);
    chk("t7_resp", resp_out, r3);
    chk("t7_tmo",  timeout_err, 0);
    ack_and_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
